// File: rtl/count_run_ctrl.sv
`timescale 1ns/1ps
// count_run_ctrl: command-driven sequencer for an up-counter.
// LOAD sets the terminal value, START runs the count at a prescaled rate
// (one step every presc+1 clocks), STOP pauses (RUN->HOLD) or clears
// (HOLD->IDLE). A one-cycle registered done pulse marks the terminal value.
// Optional build macro COUNT_RUN_WRAP_EN: the count wraps to zero at the
// terminal value and keeps running (periodic mode) instead of entering DONE.
module count_run_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [WIDTH-1:0]      count_out,
  output logic                  count_oe,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);

  state_t                  state;
  logic [WIDTH-1:0]        count;
  logic [WIDTH-1:0]        limit;
  logic [PRESCALE_W-1:0]   presc_cnt;
  logic                    oe_r;
  logic                    busy_r;
  logic                    done_r;

  logic                    accept;
  logic                    step_hit;
  logic                    at_last;

  // Only LOAD and START stall while running; STOP and NOP are always taken.
  always_comb begin
    cmd_ready = 1'b1;
    if (state == ST_RUN) begin
      cmd_ready = (cmd_op == OP_STOP) || (cmd_op == OP_NOP);
    end
  end

  assign accept   = cmd_valid && cmd_ready;
  // presc is compared live, so a drop below presc_cnt simply lets the
  // counter wrap around its full range before the next match.
  assign step_hit = (presc_cnt == presc);
  assign at_last  = (count == (limit - CNT_ONE));

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      limit     <= '0;
      presc_cnt <= '0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept && (cmd_op == OP_STOP)) begin
            // A stop on a step cycle wins: no increment, no done.
            state     <= ST_HOLD;
            presc_cnt <= '0;
            busy_r    <= 1'b0;
          end else if (step_hit) begin
            presc_cnt <= '0;
            if (at_last) begin
              done_r <= 1'b1;
`ifdef COUNT_RUN_WRAP_EN
              count  <= '0;
`else
              count  <= limit;
              state  <= ST_DONE;
              busy_r <= 1'b0;
`endif
            end else begin
              count <= count + CNT_ONE;
            end
          end else begin
            presc_cnt <= presc_cnt + PS_ONE;
          end
        end
        default: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                limit     <= cmd_data;
                count     <= '0;
                presc_cnt <= '0;
                state     <= ST_IDLE;
                oe_r      <= 1'b0;
                busy_r    <= 1'b0;
              end
              OP_START: begin
                presc_cnt <= '0;
                oe_r      <= 1'b1;
                if (limit == '0) begin
                  // Nothing to count: complete immediately.
                  state  <= ST_DONE;
                  count  <= '0;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                end else begin
                  state  <= ST_RUN;
                  busy_r <= 1'b1;
                  if (state == ST_DONE) begin
                    count <= '0;
                  end
                end
              end
              OP_STOP: begin
                if (state == ST_HOLD) begin
                  state <= ST_IDLE;
                  count <= '0;
                  oe_r  <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

  assign count_oe  = oe_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count_out = oe_r ? count : '0;

endmodule

// File: doc/count_run_ctrl.md
Name: count_run_ctrl

Overview:
- Command-driven sequencer for an up-counter datapath. It loads a terminal value, then runs the count at a programmable prescaled rate, with pause/resume, stop and completion signalling.
- Sits between the top-level pin decoding and the counter outputs: it gates the output-enable and the visible count, and drives `done`/`busy` status.

Parameters:
- WIDTH, 8, counter and terminal-value width in bits.
- PRESCALE_W, 4, prescaler width in bits; step interval is presc+1 clocks.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
- cmd_op  input  2  00 NOP, 01 LOAD, 10 START, 11 STOP.
- cmd_data  input  WIDTH  terminal value for LOAD; ignored otherwise.
- presc  input  PRESCALE_W  prescale value, sampled live every cycle.
- count_out  output  WIDTH  current count when count_oe=1, else all zeros.
- count_oe  output  1  output enable; high in every state except IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the terminal value is reached.

Behaviour:
- Reset values (rst high, asynchronous):
  - state=IDLE; count, limit, presc_cnt = 0.
  - Outputs: count_oe=0, busy=0, done=0, count_out=0.
- States: IDLE, RUN, HOLD, DONE. All registers update on the rising clk edge.
- Acceptance: a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_ready (combinational):
  - 1 in IDLE, HOLD and DONE.
  - In RUN, 1 only when cmd_op is STOP or NOP. LOAD and START stall in RUN.
- NOP: accepted with no effect.
- LOAD (IDLE/HOLD/DONE): limit<=cmd_data, count<=0, presc_cnt<=0, state<=IDLE.
- START:
  - From IDLE or HOLD: enter RUN, keeping count.
  - From DONE: count<=0, then enter RUN.
  - presc_cnt<=0 in all cases.
  - If limit==0, go to DONE instead of RUN and pulse done on the next cycle; count stays 0.
- RUN:
  - Each cycle, if presc_cnt==presc: presc_cnt<=0 and a step occurs. Otherwise presc_cnt+1.
  - Step when count==limit-1: count<=limit, state<=DONE, done=1 for exactly that cycle (registered, coincident with count reaching limit).
  - Step otherwise: count<=count+1.
- presc changed mid-run: takes effect at the next comparison. If presc drops below the current presc_cnt, the step is delayed until presc_cnt wraps at 2^PRESCALE_W back to presc (no lockup).
- STOP:
  - In RUN: state<=HOLD and presc_cnt<=0. A STOP coinciding with a step wins: no increment, no done.
  - In HOLD: state<=IDLE, count<=0.
  - In IDLE or DONE: no effect.
- DONE: count holds at limit and count_oe stays 1 until LOAD or START.
- Arithmetic: count is unsigned WIDTH bits and never exceeds limit in the no-wrap build. limit=2^WIDTH-1 runs through all values.
- Reset mid-operation: immediate return to reset values. A pending done pulse is suppressed.

Optional Feature:
- Macro: COUNT_RUN_WRAP_EN.
- Defined: in RUN, a step when count==limit-1 sets count<=0 and pulses done, but the state stays RUN (continuous periodic mode). DONE is reachable only via START with limit==0.
- Undefined: the run terminates in DONE as described above.

Test Plan:
- Reset check: rst pulse mid-RUN at count=3 -> count_out=0, count_oe=0, busy=0, done=0 immediately (asynchronous).
- Basic run: LOAD 5, presc=0, START -> count_out 1,2,3,4,5 on consecutive cycles; done high only in the cycle count=5; state DONE; busy=0; count_oe=1.
- Prescaler: LOAD 3, presc=2, START -> count increments every 3 cycles; done after 9 cycles in RUN.
- Pause/resume: LOAD 10, START; STOP at count=4 -> count holds 4, busy=0. START -> continues 5..10. STOP issued on a step cycle -> no increment.
- Handshake stall and limit 0:
  - In RUN, LOAD presented -> cmd_ready=0 and limit unchanged until STOP is accepted.
  - LOAD 0, START -> done pulse once, count_out=0.
- Wrap (COUNT_RUN_WRAP_EN): LOAD 2, presc=0, START -> count 1,0,1,0...; done pulses on every 1->0 transition; busy stays 1.
